// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle sequencer: state encoding, opcode
// constants and the opcode-to-class decode used to pick the EXEC/MEM/WB path.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsJump,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsIow,
        ClsIor
    } op_class_e;

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpGrt  = 4'b0001;
    localparam logic [3:0] OpSub  = 4'b0010;
    localparam logic [3:0] OpEq   = 4'b0011;
    localparam logic [3:0] OpJalr = 4'b0100;
    localparam logic [3:0] OpLui  = 4'b0101;
    localparam logic [3:0] OpJal  = 4'b0110;
    localparam logic [3:0] OpAddi = 4'b1000;
    localparam logic [3:0] OpLw   = 4'b1001;
    localparam logic [3:0] OpSw   = 4'b1010;
    localparam logic [3:0] OpBne  = 4'b1011;
    localparam logic [3:0] OpWri  = 4'b1100;

    // Every code not listed explicitly is treated as an IO read.
    function automatic op_class_e op_class(input logic [3:0] op);
        op_class_e cls;
        case (op)
            OpAdd, OpGrt, OpSub, OpEq, OpAddi, OpLui: cls = ClsAlu;
            OpJalr, OpJal:                            cls = ClsJump;
            OpLw:                                     cls = ClsLoad;
            OpSw:                                     cls = ClsStore;
            OpBne:                                    cls = ClsBranch;
            OpWri:                                    cls = ClsIow;
            default:                                  cls = ClsIor;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM: steps each instruction through fetch, decode,
// execute, memory and writeback, issuing per-cycle write enables, memory
// strobes and PC update controls, and counts retired instructions.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   op                      opcode from instruction register (latched in DECODE)
//   mem_ready               memory/IO access completes this cycle
//   alu_zero                ALU zero flag, used by bne in EXEC
//   IRWRITE, PCINC          instruction load and PC+1, pulsed on a completed fetch
//   PCWRITE, PCWRITECOND    unconditional / branch-taken PC load
//   MEMREAD, MEMWRITE, IOSEL memory strobes and IO-port select
//   REGWRITE                register-file write enable
//   STATE                   current state code, for debug
//   INSTRCOUNT              retired-instruction counter, wraps
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         op,
    input  logic               mem_ready,
    input  logic               alu_zero,
    output logic               IRWRITE,
    output logic               PCINC,
    output logic               PCWRITE,
    output logic               PCWRITECOND,
    output logic               MEMREAD,
    output logic               MEMWRITE,
    output logic               IOSEL,
    output logic               REGWRITE,
    output logic [2:0]         STATE,
    output logic [COUNT_W-1:0] INSTRCOUNT
);

    state_e             state_q, state_d;
    logic [3:0]         opq;
    logic [COUNT_W-1:0] count_q;
    op_class_e          cls;
    logic               retire;

    logic irwrite, pcinc, pcwrite, pcwritecond, memread, memwrite, iosel, regwrite;

    assign cls = op_class(opq);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            opq     <= 4'b0000;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                opq <= op;
            end
            if (retire) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        irwrite     = 1'b0;
        pcinc       = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        iosel       = 1'b0;
        regwrite    = 1'b0;
        case (state_q)
            StFetch: begin
                memread = 1'b1;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcinc   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StExec;
            end
            StExec: begin
                if (cls == ClsBranch) begin
                    // bne is taken when the compare result is non-zero
                    pcwritecond = ~alu_zero;
                    state_d     = StFetch;
                end else if (cls == ClsAlu || cls == ClsJump) begin
                    state_d = StWb;
                end else begin
                    state_d = StMem;
                end
            end
            StMem: begin
                memread  = (cls == ClsLoad) || (cls == ClsIor);
                memwrite = (cls == ClsStore) || (cls == ClsIow);
                iosel    = (cls == ClsIor) || (cls == ClsIow);
                if (mem_ready) begin
                    state_d = memread ? StWb : StFetch;
                end
            end
            StWb: begin
                regwrite = 1'b1;
                pcwrite  = (cls == ClsJump);
                state_d  = StFetch;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // An instruction retires on the edge that returns the FSM to FETCH.
    assign retire = (state_d == StFetch) &&
                    (state_q == StExec || state_q == StMem || state_q == StWb);

    // Outputs are forced low while reset is held so nothing leaks mid-abort.
    assign IRWRITE     = reset_n & irwrite;
    assign PCINC       = reset_n & pcinc;
    assign PCWRITE     = reset_n & pcwrite;
    assign PCWRITECOND = reset_n & pcwritecond;
    assign MEMREAD     = reset_n & memread;
    assign MEMWRITE    = reset_n & memwrite;
    assign IOSEL       = reset_n & iosel;
    assign REGWRITE    = reset_n & regwrite;
    assign STATE       = reset_n ? state_q : 3'd0;
    assign INSTRCOUNT  = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] op = 4'h0;
    logic       mem_ready = 1'b0;
    logic       alu_zero = 1'b0;

    logic        irwrite, pcinc, pcwrite, pcwritecond, memread, memwrite, iosel, regwrite;
    logic [2:0]  state;
    logic [15:0] count16;

    logic        irwrite4, pcinc4, pcwrite4, pcwritecond4, memread4, memwrite4, iosel4;
    logic        regwrite4;
    logic [2:0]  state4;
    logic [3:0]  count4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.COUNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .mem_ready   (mem_ready),
        .alu_zero    (alu_zero),
        .IRWRITE     (irwrite),
        .PCINC       (pcinc),
        .PCWRITE     (pcwrite),
        .PCWRITECOND (pcwritecond),
        .MEMREAD     (memread),
        .MEMWRITE    (memwrite),
        .IOSEL       (iosel),
        .REGWRITE    (regwrite),
        .STATE       (state),
        .INSTRCOUNT  (count16)
    );

    multicycle_sequencer #(.COUNT_W(4)) dut4 (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .mem_ready   (mem_ready),
        .alu_zero    (alu_zero),
        .IRWRITE     (irwrite4),
        .PCINC       (pcinc4),
        .PCWRITE     (pcwrite4),
        .PCWRITECOND (pcwritecond4),
        .MEMREAD     (memread4),
        .MEMWRITE    (memwrite4),
        .IOSEL       (iosel4),
        .REGWRITE    (regwrite4),
        .STATE       (state4),
        .INSTRCOUNT  (count4)
    );

    // {IRWRITE, PCINC, PCWRITE, PCWRITECOND, MEMREAD, MEMWRITE, IOSEL, REGWRITE}
    function automatic logic [7:0] outs();
        return {irwrite, pcinc, pcwrite, pcwritecond, memread, memwrite, iosel, regwrite};
    endfunction

    localparam logic [7:0] OFetch = 8'b1100_1000;
    localparam logic [7:0] OWait  = 8'b0000_1000;
    localparam logic [7:0] ONone  = 8'b0000_0000;
    localparam logic [7:0] OWb    = 8'b0000_0001;
    localparam logic [7:0] OJmpWb = 8'b0010_0001;
    localparam logic [7:0] OBrT   = 8'b0001_0000;
    localparam logic [7:0] ORd    = 8'b0000_1000;
    localparam logic [7:0] OWr    = 8'b0000_0100;
    localparam logic [7:0] OIoWr  = 8'b0000_0110;
    localparam logic [7:0] OIoRd  = 8'b0000_1010;

    typedef struct {
        logic [3:0] op;
        logic       mr;
        logic       az;
        logic [2:0] st;
        logic [7:0] o;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [3:0] o_p, input logic mr, input logic az,
                                input logic [2:0] st, input logic [7:0] o, input int cnt);
        vec_t v;
        v.op = o_p; v.mr = mr; v.az = az; v.st = st; v.o = o; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    // Called just after a falling edge: drive, settle, compare, move to next falling edge.
    task automatic run_row(input vec_t v, input string tag);
        op = v.op; mem_ready = v.mr; alu_zero = v.az;
        #1;
        check({tag, " state"}, 16'(state), 16'(v.st));
        check({tag, " outs"}, 16'(outs()), 16'(v.o));
        check({tag, " count16"}, count16, 16'(v.cnt));
        check({tag, " count4"}, 16'(count4), 16'(v.cnt % 16));
        @(negedge clk);
    endtask

    task automatic row(input logic [3:0] o_p, input logic mr, input logic az,
                       input logic [2:0] st, input logic [7:0] o, input int cnt,
                       input string tag);
        vec_t v;
        v.op = o_p; v.mr = mr; v.az = az; v.st = st; v.o = o; v.cnt = cnt;
        run_row(v, tag);
    endtask

    initial begin
        // add
        add(4'h0, 1, 0, 0, OFetch, 0); add(4'h0, 1, 0, 1, ONone, 0);
        add(4'h0, 1, 0, 2, ONone, 0);  add(4'h0, 1, 0, 4, OWb, 0);
        // lw with two wait cycles in MEM; mem_ready low in EXEC is ignored
        add(4'h9, 1, 0, 0, OFetch, 1); add(4'h9, 1, 0, 1, ONone, 1);
        add(4'h9, 0, 0, 2, ONone, 1);  add(4'h9, 0, 0, 3, ORd, 1);
        add(4'h9, 0, 0, 3, ORd, 1);    add(4'h9, 1, 0, 3, ORd, 1);
        add(4'h9, 1, 0, 4, OWb, 1);
        // bne taken; op changes in EXEC must not matter
        add(4'hB, 1, 0, 0, OFetch, 2); add(4'hB, 1, 0, 1, ONone, 2);
        add(4'h0, 1, 0, 2, OBrT, 2);
        // bne not taken
        add(4'hB, 1, 1, 0, OFetch, 3); add(4'hB, 1, 1, 1, ONone, 3);
        add(4'hB, 1, 1, 2, ONone, 3);
        // wri
        add(4'hC, 1, 0, 0, OFetch, 4); add(4'hC, 1, 0, 1, ONone, 4);
        add(4'hC, 1, 0, 2, ONone, 4);  add(4'hC, 1, 0, 3, OIoWr, 4);
        // rea
        add(4'hF, 1, 0, 0, OFetch, 5); add(4'hF, 1, 0, 1, ONone, 5);
        add(4'hF, 1, 0, 2, ONone, 5);  add(4'hF, 1, 0, 3, OIoRd, 5);
        add(4'hF, 1, 0, 4, OWb, 5);
        // jal
        add(4'h6, 1, 0, 0, OFetch, 6); add(4'h6, 1, 0, 1, ONone, 6);
        add(4'h6, 1, 0, 2, ONone, 6);  add(4'h6, 1, 0, 4, OJmpWb, 6);
        // sw with one fetch wait cycle
        add(4'hA, 0, 0, 0, OWait, 7);  add(4'hA, 1, 0, 0, OFetch, 7);
        add(4'hA, 1, 0, 1, ONone, 7);  add(4'hA, 1, 0, 2, ONone, 7);
        add(4'hA, 1, 0, 3, OWr, 7);

        // Reset held with mem_ready high: nothing may escape
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset outs", 16'(outs()), 16'(ONone));
        check("reset state", 16'(state), 16'd0);
        check("reset count16", count16, 16'd0);
        check("reset count4", 16'(count4), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_row(vecs[i], $sformatf("vec%0d", i));

        // sw aborted by reset in MEM
        row(4'hA, 1, 0, 0, OFetch, 8, "abort fetch");
        row(4'hA, 1, 0, 1, ONone, 8, "abort decode");
        row(4'hA, 1, 0, 2, ONone, 8, "abort exec");
        mem_ready = 1'b0;
        #1;
        check("abort mem outs", 16'(outs()), 16'(OWr));
        check("abort mem state", 16'(state), 16'd3);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort outs", 16'(outs()), 16'(ONone));
        check("abort state", 16'(state), 16'd0);
        check("abort count16", count16, 16'd0);
        check("abort count4", 16'(count4), 16'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("abort held outs", 16'(outs()), 16'(ONone));
        @(negedge clk);
        reset_n = 1'b1;
        row(4'h0, 0, 0, 0, OWait, 0, "post-reset fetch");

        // 16 addi: 4-bit counter wraps 15 -> 0
        for (int i = 0; i < 16; i++) begin
            row(4'h8, 1, 0, 0, OFetch, i, $sformatf("addi%0d fetch", i));
            row(4'h8, 1, 0, 1, ONone, i, $sformatf("addi%0d decode", i));
            row(4'h8, 1, 0, 2, ONone, i, $sformatf("addi%0d exec", i));
            row(4'h8, 1, 0, 4, OWb, i, $sformatf("addi%0d wb", i));
        end
        #1;
        check("wrap count4", 16'(count4), 16'd0);
        check("wrap count16", count16, 16'd16);
        check("wrap state", 16'(state), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
